// File: rtl/am_fm_carrier_mod_pkg.sv
// -----------------------------------------------------------------------------
// am_fm_carrier_mod_pkg
// Shared constants and helpers for the AM/FM carrier modulator.
//   - Datapath widths (M, L, W, WOUT) and derived internal widths.
//   - Pipeline latency: 5 cycles, or 6 when DAC_COMP_EN is defined
//     (an inverse-sinc FIR stage is added in front of the output register).
//   - Output saturation bounds, unity AM gain, FM and output shift amounts.
//   - sine_q15(): elaboration-time sine table entry, used to fill the ROM.
//   - sat_out(): clamp to the signed WOUT-bit DAC range.
// -----------------------------------------------------------------------------
package am_fm_carrier_mod_pkg;

    localparam int M      = 24;   // phase accumulator / tuning word width
    localparam int L      = 12;   // sine ROM address bits
    localparam int W      = 16;   // sine ROM data width (signed)
    localparam int WOUT   = 14;   // DAC word width (signed)
    localparam int DIN_W  = 16;   // modulating sample width

    localparam int GAIN_W    = 18;             // signed gain, 0..65535
    localparam int PROD_W    = W + GAIN_W;     // sine * gain
    localparam int FM_SHIFT  = 8;
    localparam int AM_SHIFT  = 16;
    localparam int OUT_SHIFT = 18;
    localparam int XW        = PROD_W - OUT_SHIFT;  // width of prod >>> OUT_SHIFT
    localparam int SAT_W     = 24;                  // headroom ahead of saturation

    localparam int UNITY_GAIN = 32768;
    localparam int SAT_MAX    = (2 ** (WOUT - 1)) - 1;
    localparam int SAT_MIN    = -(2 ** (WOUT - 1));

`ifdef DAC_COMP_EN
    localparam int LATENCY = 6;
`else
    localparam int LATENCY = 5;
`endif

    // Full-wave sine sample for table index idx (0 .. 2**L-1), peak 32767.
    // Computed from a quarter wave with a fixed-point (Q30) Taylor series so
    // the table is built at elaboration time without real arithmetic.
    function automatic logic signed [W-1:0] sine_q15(input int idx);
        int     quarter;
        int     quad;
        int     k;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint mag;
        quarter = 2 ** (L - 2);
        quad    = idx / quarter;
        k       = idx % quarter;
        if (quad == 1 || quad == 3) begin
            k = quarter - k;
        end
        // pi/2 in Q30 scaled by k/quarter
        x    = (64'sd1686629713 * longint'(k)) / longint'(quarter);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 6; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        mag = (sum * 32767 + (64'sd1 <<< 29)) >>> 30;
        if (mag > 32767) begin
            mag = 32767;
        end
        if (mag < 0) begin
            mag = 0;
        end
        return (quad >= 2) ? -W'(mag) : W'(mag);
    endfunction

    // Clamp to the signed WOUT-bit output range.
    function automatic logic signed [WOUT-1:0] sat_out(input logic signed [SAT_W-1:0] x);
        if (x > SAT_W'(SAT_MAX)) begin
            return WOUT'(SAT_MAX);
        end else if (x < SAT_W'(SAT_MIN)) begin
            return WOUT'(SAT_MIN);
        end else begin
            return WOUT'(x);
        end
    endfunction

endpackage

// File: rtl/am_fm_carrier_mod_sin_rom.sv
// -----------------------------------------------------------------------------
// carrier_sin_rom
// Registered full-wave sine ROM, 2**L entries of W-bit signed samples,
// peak +/-32767. One cycle read latency; reads every cycle.
// Ports:
//   clk   in   system clock
//   addr  in   L-bit phase (top bits of the accumulator)
//   dout  out  W-bit signed sine sample, registered
// -----------------------------------------------------------------------------
module carrier_sin_rom
    import am_fm_carrier_mod_pkg::*;
(
    input  logic                clk,
    input  logic [L-1:0]        addr,
    output logic signed [W-1:0] dout
);

    logic signed [W-1:0] rom [2**L];

    // Table contents are constants resolved at elaboration.
    for (genvar i = 0; i < 2**L; i++) begin : g_rom
        localparam logic signed [W-1:0] VAL = sine_q15(i);
        assign rom[i] = VAL;
    end

    always_ff @(posedge clk) begin
        dout <= rom[addr];
    end

endmodule

// File: rtl/am_fm_carrier_mod.sv
// -----------------------------------------------------------------------------
// am_fm_carrier_mod
// Final modulator stage: phase-accumulator carrier with FM (sample offsets
// the tuning word) or AM (sample scales the carrier amplitude), saturated to
// a signed WOUT-bit DAC word.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   val_in      in   input sample strobe
//   i_data      in   signed 16-bit modulating sample
//   c_fm_am     in   0 = AM, 1 = FM (captured with each sample)
//   c_comp_dac  in   select inverse-sinc filtered output (DAC_COMP_EN only)
//   frec_por    in   carrier tuning word (captured with each sample)
//   im_am       in   AM index, unsigned Q0.16
//   im_fm       in   FM index, unsigned
//   o_data      out  signed WOUT-bit modulated output
//   val_out     out  output strobe
//
// Handshake: val_in is a one-cycle strobe with no backpressure; every stage
// advances only when its copy of the strobe is set, and val_out is val_in
// delayed by LATENCY cycles, one pulse per accepted sample. Data registers
// hold their value while no strobe is present.
//
// Pipeline: S1 capture + dev/gain, S2 phase accumulate, S3 ROM read,
// S4 sine*gain, S5 shift+saturate. With `define DAC_COMP_EN an FIR stage
// (taps -1/16, 9/8, -1/16) sits between S5's shift and the output register.
// -----------------------------------------------------------------------------
module am_fm_carrier_mod
    import am_fm_carrier_mod_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    val_in,
    input  logic signed [DIN_W-1:0] i_data,
    input  logic                    c_fm_am,
    input  logic                    c_comp_dac,
    input  logic [M-1:0]            frec_por,
    input  logic [15:0]             im_am,
    input  logic [15:0]             im_fm,
    output logic signed [WOUT-1:0]  o_data,
    output logic                    val_out
);

    localparam int PW = 2 * DIN_W + 1;  // signed sample * zero-extended index

    logic [LATENCY-1:0]       vpipe;
    logic signed [PW-1:0]     fm_prod;
    logic signed [PW-1:0]     am_prod;
    logic [M-1:0]             dev_c;
    logic signed [GAIN_W-1:0] gain_c;

    logic [M-1:0]             frec1;
    logic [M-1:0]             dev1;
    logic signed [GAIN_W-1:0] gain1;
    logic [M-1:0]             acc;
    logic [L-1:0]             phase2;
    logic signed [GAIN_W-1:0] gain2;
    logic signed [W-1:0]      sine3;
    logic signed [GAIN_W-1:0] gain3;
    logic signed [PROD_W-1:0] prod4;
    logic signed [XW-1:0]     x_c;

    // S1 arithmetic: FM deviation or AM gain, the other forced to neutral.
    always_comb begin
        fm_prod = PW'(i_data) * $signed(PW'(im_fm));
        am_prod = PW'(i_data) * $signed(PW'(im_am));
        dev_c   = '0;
        gain_c  = GAIN_W'(UNITY_GAIN);
        if (c_fm_am) begin
            dev_c = M'(fm_prod >>> FM_SHIFT);
        end else begin
            gain_c = GAIN_W'(UNITY_GAIN) + GAIN_W'(am_prod >>> AM_SHIFT);
        end
    end

    // ROM address is the phase before this sample's increment, so the first
    // sample after reset sits at phase 0.
    carrier_sin_rom u_sin_rom (
        .clk  (clk),
        .addr (phase2),
        .dout (sine3)
    );

    assign x_c     = XW'(prod4 >>> OUT_SHIFT);
    assign val_out = vpipe[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe  <= '0;
            frec1  <= '0;
            dev1   <= '0;
            gain1  <= '0;
            acc    <= '0;
            phase2 <= '0;
            gain2  <= '0;
            gain3  <= '0;
            prod4  <= '0;
        end else begin
            vpipe <= {vpipe[LATENCY-2:0], val_in};
            if (val_in) begin
                frec1 <= frec_por;
                dev1  <= dev_c;
                gain1 <= gain_c;
            end
            if (vpipe[0]) begin
                acc    <= acc + frec1 + dev1;   // modulo 2**M
                phase2 <= acc[M-1:M-L];
                gain2  <= gain1;
            end
            // gain3 lines up with the ROM output register
            if (vpipe[1]) begin
                gain3 <= gain2;
            end
            if (vpipe[2]) begin
                prod4 <= PROD_W'(sine3) * PROD_W'(gain3);
            end
        end
    end

`ifdef DAC_COMP_EN
    logic signed [XW-1:0]    x5;
    logic signed [XW-1:0]    xd1;
    logic signed [XW-1:0]    xd2;
    logic signed [SAT_W-1:0] fir_c;

    // -x[n]/16 + 9/8 x[n-1] - x[n-2]/16 == (18 x[n-1] - x[n] - x[n-2]) / 16
    assign fir_c = (SAT_W'(xd1) * SAT_W'(18) - SAT_W'(x5) - SAT_W'(xd2)) >>> 4;

    always_ff @(posedge clk) begin
        if (rst) begin
            x5     <= '0;
            xd1    <= '0;
            xd2    <= '0;
            o_data <= '0;
        end else begin
            if (vpipe[3]) begin
                x5  <= x_c;
                xd1 <= x5;
                xd2 <= xd1;
            end
            if (vpipe[4]) begin
                o_data <= sat_out(c_comp_dac ? fir_c : SAT_W'(x5));
            end
        end
    end
`else
    logic unused_comp_dac;
    assign unused_comp_dac = c_comp_dac;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data <= '0;
        end else if (vpipe[3]) begin
            o_data <= sat_out(SAT_W'(x_c));
        end
    end
`endif

endmodule

// File: tb/tb_am_fm_carrier_mod.sv
// -----------------------------------------------------------------------------
// tb_am_fm_carrier_mod
// Directed bench for am_fm_carrier_mod: carrier-only, AM extremes, FM
// deviation, isolated strobes, and reset with samples in flight. A reference
// model (real-valued sine) fills an expected queue; a monitor pops it on each
// val_out and checks value, latency and hold behaviour between outputs.
// -----------------------------------------------------------------------------
module tb_am_fm_carrier_mod;

`ifdef DAC_COMP_EN
    localparam int LAT = 6;
    localparam int TOL = 2;
`else
    localparam int LAT = 5;
    localparam int TOL = 1;
`endif

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               val_in = 1'b0;
    logic signed [15:0] i_data = '0;
    logic               c_fm_am = 1'b0;
    logic               c_comp_dac = 1'b0;
    logic [23:0]        frec_por = '0;
    logic [15:0]        im_am = '0;
    logic [15:0]        im_fm = '0;
    logic signed [13:0] o_data;
    logic               val_out;

    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    am_fm_carrier_mod dut (
        .clk        (clk),
        .rst        (rst),
        .val_in     (val_in),
        .i_data     (i_data),
        .c_fm_am    (c_fm_am),
        .c_comp_dac (c_comp_dac),
        .frec_por   (frec_por),
        .im_am      (im_am),
        .im_fm      (im_fm),
        .o_data     (o_data),
        .val_out    (val_out)
    );

    // ---------------- scoreboard ----------------
    logic signed [13:0] exp_q[$];
    int                 due_q[$];
    int                 n_checks = 0;
    int                 n_errors = 0;
    logic signed [13:0] last_exp = '0;
    int                 obs_max;
    int                 obs_min;

    logic [23:0] m_acc = '0;
    longint      m_x1 = 0;
    longint      m_x2 = 0;

    task automatic check(input string tag, input longint obs, input longint exp, input int tol);
        n_checks++;
        if (obs - exp > tol || exp - obs > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    function automatic int ref_sine(input logic [11:0] idx);
        real s;
        s = 32767.0 * $sin(2.0 * 3.14159265358979 * idx / 4096.0);
        return (s >= 0.0) ? $rtoi(s + 0.5) : $rtoi(s - 0.5);
    endfunction

    function automatic longint sat14(input longint v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    always @(negedge clk) begin
        logic signed [13:0] e;
        int                 d;
        if (rst) begin
            last_exp = '0;
        end else if (val_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_val_out", val_out, 0, 0);
            end else begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("o_data", o_data, e, TOL);
                check("latency", cyc, d, 0);
                last_exp = e;
                if (o_data > obs_max) obs_max = o_data;
                if (o_data < obs_min) obs_min = o_data;
            end
        end else begin
            check("hold_o_data", o_data, last_exp, TOL);
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; presents one sample for one cycle.
    task automatic send(input logic signed [15:0] d);
        longint dev;
        longint gain;
        longint x;
        longint y;
        int     s;
        dev  = c_fm_am ? ((longint'(d) * longint'(im_fm)) >>> 8) : 0;
        gain = c_fm_am ? 32768 : 32768 + ((longint'(d) * longint'(im_am)) >>> 16);
        s    = ref_sine(m_acc[23:12]);
        m_acc = m_acc + frec_por + dev[23:0];
        x    = (longint'(s) * gain) >>> 18;
`ifdef DAC_COMP_EN
        y    = c_comp_dac ? sat14((18 * m_x1 - x - m_x2) >>> 4) : sat14(x);
        m_x2 = m_x1;
        m_x1 = x;
`else
        y    = sat14(x);
`endif
        exp_q.push_back(14'(y));
        due_q.push_back(cyc + LAT);
        i_data = d;
        val_in = 1'b1;
        @(posedge clk);
        #1;
        val_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_pending", exp_q.size(), 0, 0);
        idle(2);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_q.delete();
        due_q.delete();
        m_acc = '0;
        m_x1  = 0;
        m_x2  = 0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_stats();
        obs_max = -100000;
        obs_min = 100000;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic signed [15:0] hs_vec [6];
        hs_vec = '{16'sd12000, -16'sd20000, 16'sd32767, -16'sd32768, 16'sd5, 16'sd0};

        do_reset(3);
        @(negedge clk);
        check("reset_o_data", o_data, 0, 0);
        check("reset_val_out", val_out, 0, 0);
        @(posedge clk);
        #1;

        // Carrier only: 16-sample period, half-scale peak.
        c_fm_am  = 1'b1;
        im_fm    = 16'h0000;
        frec_por = 24'h100000;
        clear_stats();
        for (int i = 0; i < 32; i++) send(16'(i * 1000 - 16000));
        drain();
        check("carrier_peak", obs_max, 4095, 1);
        check("carrier_trough", obs_min, -4096, 1);

        // AM extremes.
        c_fm_am = 1'b0;
        im_am   = 16'hFFFF;
        clear_stats();
        for (int i = 0; i < 16; i++) send(-16'sd32768);
        drain();
        check("am_zero_max", obs_max, 0, 0);
        check("am_zero_min", obs_min, 0, 0);
        clear_stats();
        for (int i = 0; i < 16; i++) send(16'sd32767);
        drain();
        check("am_full_peak", obs_max, 8190, 1);
        check("am_full_trough", obs_min, -8191, 1);

        // FM deviation: step 24'h080000 + 16384, then negative deviation.
        c_fm_am  = 1'b1;
        frec_por = 24'h080000;
        im_fm    = 16'h0100;
        for (int i = 0; i < 20; i++) send(16'sd16384);
        for (int i = 0; i < 6; i++) send(-16'sd16384);
        for (int i = 0; i < 4; i++) send(16'sd0);
        drain();

        // Isolated strobes with 3 idle cycles between them.
        c_fm_am  = 1'b0;
        im_am    = 16'h8000;
        frec_por = 24'h0A3D71;
        for (int i = 0; i < 6; i++) begin
            send(hs_vec[i]);
            idle(3);
        end
        drain();

`ifdef DAC_COMP_EN
        c_comp_dac = 1'b1;
        c_fm_am    = 1'b1;
        im_fm      = 16'h0000;
        frec_por   = 24'h100000;
        for (int i = 0; i < 16; i++) send(16'sd0);
        drain();
        c_comp_dac = 1'b0;
`endif

        // Reset with three samples in flight.
        c_fm_am  = 1'b1;
        im_fm    = 16'h0040;
        frec_por = 24'h100000;
        send(16'sd1000);
        send(-16'sd2000);
        send(16'sd3000);
        do_reset(1);
        @(negedge clk);
        check("midrst_o_data", o_data, 0, 0);
        check("midrst_val_out", val_out, 0, 0);
        @(posedge clk);
        #1;
        idle(8);
        send(16'sd0);
        send(16'sd0);
        send(16'sd500);
        drain();

        check("queue_empty", exp_q.size(), 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/am_fm_carrier_mod.md
Name: am_fm_carrier_mod

Overview:
- Final stage of the modulator datapath, fed by the CIC interpolator output (signed 16-bit modulating samples plus a valid strobe).
- Generates the carrier with a phase accumulator and a sine ROM.
- Applies FM (modulating sample offsets the carrier tuning word) or AM (modulating sample scales the carrier amplitude).
- Drives the signed 14-bit DAC word with saturation.

Parameters:
- M, 24: phase accumulator / tuning word width.
- L, 12: sine ROM address bits (top L bits of accumulator).
- W, 16: sine ROM data width, signed.
- WOUT, 14: output width to DAC.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- val_in  in  1  input sample valid (one-cycle strobes, any rate up to every cycle).
- i_data  in  16  signed modulating sample (CIC output).
- c_fm_am  in  1  mode select: 0 = AM, 1 = FM; sampled with each valid sample.
- c_comp_dac  in  1  DAC compensation select (used only with DAC_COMP_EN).
- frec_por  in  M  carrier tuning word, unsigned.
- im_am  in  16  AM index, unsigned Q0.16.
- im_fm  in  16  FM index, unsigned.
- o_data  out  WOUT  signed modulated output.
- val_out  out  1  output valid.

Behaviour:
- Single clock. Reset is synchronous, active-high.
- During rst, all of these clear to 0: accumulator, pipeline registers, valid pipe, o_data, val_out.
- All stages advance only on valid-qualified enables. Data registers hold while no valid is present.
- S1, on val_in:
  - Register i_data and c_fm_am.
  - dev = (i_data * {1'b0,im_fm}) >>> 8, a 33-bit signed product. Sign-extend/truncate to M bits.
  - gain = 32768 + ((i_data * {1'b0,im_am}) >>> 16): 18-bit signed, range 0..65535, where 32768 = unity.
  - In FM mode gain = 32768. In AM mode dev = 0.
- S2: acc <= acc + frec_por + dev, modulo 2^M; wrap-around is silent. acc advances only on stage-valid. With no valid, phase holds.
- S3: ROM read at acc[M-1:M-L], registered; returns a signed W-bit sine with peak 32767.
- S4: prod = sine * gain, 34-bit signed. gain is delayed to align with S3.
- S5: o_data = sat_WOUT(prod >>> 18). Saturation clamps to +8191 / -8192.
  - Unmodulated carrier peak is therefore ~4095 (half scale). 100% AM reaches full scale.
- Latency: val_out is val_in delayed exactly 5 cycles, one pulse per input pulse. Back-to-back inputs give back-to-back outputs.
- Mode or frec_por change mid-stream takes effect from the next sample accepted in S1. No glitch, and no accumulator reset.
- Reset asserted mid-stream: in-flight samples are discarded and no val_out is produced for them. The first sample after reset release starts at phase 0.

Optional Feature:
- Macro DAC_COMP_EN.
- Defined:
  - Inserts a 3-tap inverse-sinc FIR, coefficients [-1/16, 9/8, -1/16], applied to consecutive valid samples of prod >>> 18, before saturation.
  - When c_comp_dac = 1 the filtered value is selected; when 0 the unfiltered value is selected.
  - Latency becomes 6 cycles in both settings; the bypass path is delayed to match.
  - FIR taps reset to 0.
- Undefined: no FIR; c_comp_dac is ignored; latency is 5.

Decomposition:
- Shared package holds:
  - constants M, L, W, WOUT;
  - the pipeline latency constant (5, or 6 with DAC_COMP_EN);
  - saturation bounds;
  - unity gain 32768;
  - FM shift 8 and output shift 18.
- One sub-module: carrier_sin_rom. It is a registered full-wave 2^L x W signed ROM with ports clk, addr, dout.

Test Plan:
- Carrier only:
  - Stimulus: FM mode, im_fm = 0, frec_por = 24'h100000, val_in every cycle.
  - Response: o_data period exactly 16 samples, peak 4095 ±1, val_out continuous after 5-cycle latency.
- AM extremes:
  - Stimulus: AM mode, im_am = 16'hFFFF, i_data = -32768 constant.
  - Response: gain 0, o_data = 0.
  - Stimulus: same with i_data = +32767.
  - Response: peak 8190 ±1, no wrap.
- FM deviation:
  - Stimulus: frec_por = 24'h080000, im_fm = 16'h0100, i_data = +16384.
  - Response: effective step 24'h080000 + 16384; phase advances accordingly, verified against a reference model.
- Handshake/latency:
  - Stimulus: isolated val_in pulses separated by 3 idle cycles.
  - Response: each val_out exactly 5 cycles later, single pulse each. Output and phase hold during gaps.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle with 3 samples in flight.
  - Response: o_data = 0 and val_out = 0 the next cycle; none of the 3 samples emerge.
  - The next sample is computed from phase 0.
- With DAC_COMP_EN:
  - Stimulus: c_comp_dac toggled.
  - Response: latency 6 in both settings. An impulse-like input shows taps -1/16, 9/8, -1/16 when c_comp_dac = 1, and passes through when 0.
